// File: rtl/wave_reader_n.sv
// Multi-mode waveform reader: phase accumulator feeding a two-stage pipeline that
// addresses an external quarter-wave sine ROM and shapes sine/square/saw/triangle samples.
module wave_reader_n #(
   parameter int ACC_W    = 22,
   parameter int STEP_W   = 20,
   parameter int ADDR_W   = 10,
   parameter int SAMPLE_W = 16
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [STEP_W-1:0]          step_size,
   input  logic                       generate_next,
   input  logic [1:0]                 mode,
   input  logic                       phase_clear,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [SAMPLE_W-1:0]        rom_data,
   output logic signed [SAMPLE_W-1:0] sample,
   output logic                       sample_ready,
   output logic                       busy
);

   localparam logic [SAMPLE_W-1:0] LP_POS_FULL = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] LP_NEG_FULL = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};

   logic [ACC_W-1:0]    r_acc;
   logic [ACC_W-1:0]    w_acc_nxt;
   logic [ACC_W-1:0]    w_step;
   logic [ACC_W-1:0]    r_p_p1;
   logic [1:0]          r_mode_p1;
   logic                r_vld_p1;
   logic [SAMPLE_W-1:0] r_t_p2;
   logic [1:0]          r_mode_p2;
   logic                r_vld_p2;
   logic                w_unused_p1;

   // Quadrants 01 and 11 run the quarter-wave table backwards.
   function automatic logic [ADDR_W-1:0] f_rom_addr(input logic [ACC_W-1:0] p);
      logic [ADDR_W-1:0] raw;
      raw = p[ACC_W-3 -: ADDR_W];
      return p[ACC_W-2] ? ~raw : raw;
   endfunction

   function automatic logic signed [SAMPLE_W-1:0] f_shape(
      input logic [SAMPLE_W-1:0] t,
      input logic [1:0]          m,
      input logic [SAMPLE_W-1:0] mag
   );
      logic [SAMPLE_W-2:0] f;
      logic [SAMPLE_W-1:0] res;
      f = t[SAMPLE_W-2:0] ^ {(SAMPLE_W-1){t[SAMPLE_W-1]}};
      case (m)
         2'b00:   res = t[SAMPLE_W-1] ? ({SAMPLE_W{1'b0}} - mag) : mag;
         2'b01:   res = t[SAMPLE_W-1] ? LP_NEG_FULL : LP_POS_FULL;
         2'b10:   res = {~t[SAMPLE_W-1], t[SAMPLE_W-2:0]};
         default: res = {~f[SAMPLE_W-2], f[SAMPLE_W-3:0], 1'b0};
      endcase
      return res;
   endfunction

   assign w_step = ACC_W'(step_size);

   always_comb begin
      w_acc_nxt = r_acc;
      if (phase_clear) begin
         w_acc_nxt = generate_next ? w_step : {ACC_W{1'b0}};
      end else if (generate_next) begin
         w_acc_nxt = r_acc + w_step;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
      end else begin
         r_acc <= w_acc_nxt;
      end
   end

   // Stage 1: capture the post-increment phase; rom_addr is derived from it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_p_p1    <= '0;
         r_mode_p1 <= '0;
         r_vld_p1  <= 1'b0;
      end else begin
         r_vld_p1 <= generate_next;
         if (generate_next) begin
            r_p_p1    <= w_acc_nxt;
            r_mode_p1 <= mode;
         end
      end
   end

   assign rom_addr    = f_rom_addr(r_p_p1);
   assign w_unused_p1 = ^r_p_p1;

   // Stage 2: only the top SAMPLE_W phase bits matter for shaping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_t_p2    <= '0;
         r_mode_p2 <= '0;
         r_vld_p2  <= 1'b0;
      end else begin
         r_vld_p2 <= r_vld_p1;
         if (r_vld_p1) begin
            r_t_p2    <= r_p_p1[ACC_W-1 -: SAMPLE_W];
            r_mode_p2 <= r_mode_p1;
         end
      end
   end

   // Output stage: rom_data now reflects the stage-2 address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample       <= '0;
         sample_ready <= 1'b0;
      end else begin
         sample_ready <= r_vld_p2;
         if (r_vld_p2) begin
            sample <= f_shape(r_t_p2, r_mode_p2, rom_data);
         end
      end
   end

   assign busy = r_vld_p1 | r_vld_p2;

endmodule

// File: doc/wave_reader_n.md
Name: wave_reader_n

Overview:
- Parametrised multi-mode waveform reader.
- Holds a phase accumulator and, per request, produces one signed sample.
- Modes: quarter-wave-ROM sine, square, sawtooth or triangle.
- Replaces the fixed-width sine-only reader in the note-player datapath.
- Drives an external synchronous sine ROM.
- Fully pipelined: one request accepted per cycle, fixed 2-edge latency.

Parameters:
- ACC_W, 22: phase accumulator width. The top 2 bits are the quadrant. Requires ACC_W >= ADDR_W+2, ACC_W >= SAMPLE_W and ACC_W >= STEP_W.
- STEP_W, 20: step_size width. Zero-extended to ACC_W.
- ADDR_W, 10: sine ROM address width (quarter wave, 2^ADDR_W entries).
- SAMPLE_W, 16: sample width, two's complement.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- step_size  in  STEP_W  phase increment; sampled on the accepting edge.
- generate_next  in  1  request strobe. Each high cycle is one request.
- mode  in  2  00 sine, 01 square, 10 saw, 11 triangle; sampled on the accepting edge.
- phase_clear  in  1  synchronous accumulator clear.
- rom_addr  out  ADDR_W  address to the sine ROM. The ROM registers its data one edge after the address.
- rom_data  in  SAMPLE_W  ROM output. Non-negative quarter-wave magnitude.
- sample  out  SAMPLE_W  registered output sample.
- sample_ready  out  1  one-cycle pulse per completed request.
- busy  out  1  high while any request is in flight (stage-1 or stage-2 valid).

Behaviour:
- Reset (async, any time):
  - acc, stage-1 and stage-2 registers and all valid bits go to 0.
  - sample=0, sample_ready=0, busy=0, rom_addr=0.
  - In-flight requests are dropped; no sample_ready follows them.
- Accumulator update on each rising edge:
  - phase_clear=1, generate_next=0: acc <= 0.
  - phase_clear=1, generate_next=1: acc <= step.
  - phase_clear=0, generate_next=1: acc <= acc+step, modulo 2^ACC_W (wraps silently).
  - Otherwise: hold.
- Request at edge E0:
  - Stage 1 captures p = the new acc value (post-increment), the mode, and valid=1.
- Between E0 and E1, rom_addr is combinational from stage-1 p:
  - q = p[ACC_W-1:ACC_W-2].
  - raw = p[ACC_W-3 -: ADDR_W].
  - rom_addr = ~raw when q is 01 or 11, else raw.
  - When stage 1 is not valid, rom_addr holds from the last stage-1 p.
- At E1: stage 2 captures p, mode and valid. rom_data is valid after E1.
- At E2: sample and sample_ready are registered from stage 2 and rom_data.
  - sample_ready is high for exactly the cycle E2..E3.
  - Latency is 2 edges. Throughput is one sample per cycle.
- sample when sample_ready=0: holds its last value.
- Mode arithmetic (all SAMPLE_W, wrap on overflow). M = 2^(SAMPLE_W-1)-1. t = top SAMPLE_W bits of p.
  - sine: rom_data when q is 00 or 01; 0-rom_data when q is 10 or 11.
  - square: +M when p MSB=0, else -M.
  - saw: t with its MSB inverted (offset binary to two's complement).
  - triangle: f = t[SAMPLE_W-2:0], bitwise-inverted when t MSB=1. sample = {f,0} with its MSB inverted. Minimum at phase 0, peak at half cycle.
- Mode or step_size changing while requests are in flight does not affect those requests.
- Reset takes priority over every other input.

Test Plan:
- Sine, single step:
  - Stimulus: reset; mode=00, step=0x00400; one generate_next pulse at E0.
  - Required: rom_addr=0x001 in cycle E0..E1; sample_ready pulse E2..E3; sample=rom[1]; busy high E0..E2.
- Quadrant mirroring:
  - Stimulus: step=0xFFC00; three requests.
  - Phases 0x0FFC00, 0x1FF800, 0x2FF400 give rom_addr 0x3FF, 0x001, 0x3FD.
  - Samples: rom[0x3FF], rom[0x001], 0-rom[0x3FD].
- Back-to-back:
  - Stimulus: generate_next high 4 cycles; step=0x00400.
  - Required: sample_ready high 4 consecutive cycles starting E2; samples rom[1], rom[2], rom[3], rom[4].
- Square and saw:
  - mode=01, step=0x80000: samples 0x7FFF, 0x7FFF, 0x7FFF, then 0x8001 at phase 0x200000.
  - mode=10 at phase 0x200000: sample 0x0000.
  - mode=11 at phase 0: sample 0x8000.
- Reset mid-flight:
  - Stimulus: request at E0; assert reset between E1 and E2.
  - Required: no sample_ready pulse; sample=0; acc=0; next request with step 0x00400 gives rom_addr 1.
- Wrap and clear:
  - Stimulus: acc=0x3FFC00, step=0x00800.
  - Required: acc wraps to 0x000400.
  - Stimulus: phase_clear with generate_next, step=0x00400.
  - Required: acc=0x000400 and rom_addr=0x001. phase_clear alone gives acc=0 with no sample_ready.
